// File: rtl/gray_sync_decoder_pkg.sv
// Shared gray-code helpers for both ends of the gray CDC path.
// Holds the code conversions, a popcount for step checking, and the
// decoder FSM state encoding. Functions work on up to 32-bit values;
// narrower callers zero-extend on the way in and truncate on the way out.
package gray_cdc_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Zero upper bits contribute nothing to the prefix XOR, so narrow codes
    // decode correctly when zero-extended.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    function automatic logic [5:0] popcount(input logic [GRAY_MAX_W-1:0] v);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            cnt = cnt + {5'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gray_sync_decoder_if.sv
// Bus between a gray-code source and the gray sync decoder.
// The decoder takes the slave side; whoever drives the gray value and
// consumes the decoded result takes the master side.
interface gray_sync_decoder_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] i_gray_async;
    logic [WIDTH-1:0] o_bin;
    logic             o_bin_vld;
    logic [WIDTH-1:0] o_delta;
    logic             o_err;
    logic             o_err_sticky;

    modport master (
        output i_gray_async,
        input  o_bin, o_bin_vld, o_delta, o_err, o_err_sticky
    );

    modport slave (
        input  i_gray_async,
        output o_bin, o_bin_vld, o_delta, o_err, o_err_sticky
    );
endinterface

// File: rtl/gray_sync_decoder_sync.sv
// Plain multi-flop synchroniser chain, reset to zero.
// Generic enough to reuse on any CDC path; carries no knowledge of gray codes.
module sync_ff_chain #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];

    // Each stage takes the one before it; stage 0 samples the async input.
    always_comb begin
        sync_d[0] = d;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Register the chain, flushing every stage to zero on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gray_sync_decoder.sv
// Receive side of a gray-code CDC path: synchronises a gray count from a
// slower domain, decodes it to binary and reports every new value with a
// one-cycle valid pulse and its modular step size.
// Optional macro GRAY_CHECK_EN: flags multi-bit gray changes on o_err /
// o_err_sticky and discards them; without it those outputs are tied low.
module gray_sync_decoder
    import gray_cdc_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic                 i_clk,
    input logic                 i_rst,
    gray_sync_decoder_if.slave  bus
);

    localparam logic [2:0] FILL_LAST = 3'(SYNC_STAGES);

    logic [WIDTH-1:0] g_s;
    logic [WIDTH-1:0] g_dec;
    logic             step_ok;

    state_t           state_q, state_d;
    logic [2:0]       fill_cnt_q, fill_cnt_d;
    logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             bin_vld_q, bin_vld_d;
    logic [WIDTH-1:0] delta_q, delta_d;
`ifdef GRAY_CHECK_EN
    logic             err_q, err_d;
    logic             err_sticky_q, err_sticky_d;
`endif

    sync_ff_chain #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (i_clk),
        .rst (i_rst),
        .d   (bus.i_gray_async),
        .q   (g_s)
    );

    assign g_dec = WIDTH'(gray2bin(GRAY_MAX_W'(g_s)));

    // A change is acceptable unless checking is on and more than one bit moved.
    always_comb begin
`ifdef GRAY_CHECK_EN
        step_ok = (popcount(GRAY_MAX_W'(g_s ^ prev_gray_q)) <= 6'd1);
`else
        step_ok = 1'b1;
`endif
    end

    // INIT waits out the reset-flushed sync chain and loads silently; RUN
    // reports each new synchronised value once.
    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        prev_gray_d = prev_gray_q;
        bin_d       = bin_q;
        bin_vld_d   = 1'b0;
        delta_d     = delta_q;
`ifdef GRAY_CHECK_EN
        err_d        = 1'b0;
        err_sticky_d = err_sticky_q;
`endif
        case (state_q)
            ST_INIT: begin
                if (fill_cnt_q == FILL_LAST) begin
                    bin_d       = g_dec;
                    prev_gray_d = g_s;
                    state_d     = ST_RUN;
                end else begin
                    fill_cnt_d = fill_cnt_q + 3'd1;
                end
            end
            ST_RUN: begin
                if (g_s != prev_gray_q) begin
                    if (step_ok) begin
                        bin_d       = g_dec;
                        delta_d     = g_dec - bin_q;
                        bin_vld_d   = 1'b1;
                        prev_gray_d = g_s;
                    end
`ifdef GRAY_CHECK_EN
                    else begin
                        err_d        = 1'b1;
                        err_sticky_d = 1'b1;
                    end
`endif
                end
            end
        endcase
    end

    // State and registered outputs, all cleared by synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_INIT;
            fill_cnt_q   <= '0;
            prev_gray_q  <= '0;
            bin_q        <= '0;
            bin_vld_q    <= 1'b0;
            delta_q      <= '0;
`ifdef GRAY_CHECK_EN
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            fill_cnt_q   <= fill_cnt_d;
            prev_gray_q  <= prev_gray_d;
            bin_q        <= bin_d;
            bin_vld_q    <= bin_vld_d;
            delta_q      <= delta_d;
`ifdef GRAY_CHECK_EN
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
`endif
        end
    end

    assign bus.o_bin     = bin_q;
    assign bus.o_bin_vld = bin_vld_q;
    assign bus.o_delta   = delta_q;
`ifdef GRAY_CHECK_EN
    assign bus.o_err        = err_q;
    assign bus.o_err_sticky = err_sticky_q;
`else
    assign bus.o_err        = 1'b0;
    assign bus.o_err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Testbench for gray_sync_decoder (WIDTH=4, SYNC_STAGES=2).
// Stimulus pushes expected (bin, delta) pairs into a queue; a monitor pops
// and compares on every o_bin_vld pulse. Honours GRAY_CHECK_EN for the
// multi-bit jump expectations.
module tb_gray_sync_decoder;

    typedef struct {
        logic [3:0] bin;
        logic [3:0] delta;
    } exp_t;

    logic i_clk;
    logic i_rst;

    int tests_run    = 0;
    int tests_failed = 0;
    int err_pulses   = 0;
    int err_exp      = 0;

    exp_t       exp_q[$];
    logic [3:0] last_bin;

    // Hand-written 4-bit gray code table, indexed by binary value.
    logic [3:0] gray_tab [16] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0010,
        4'b0110, 4'b0111, 4'b0101, 4'b0100,
        4'b1100, 4'b1101, 4'b1111, 4'b1110,
        4'b1010, 4'b1011, 4'b1001, 4'b1000
    };

    gray_sync_decoder_if #(.WIDTH(4)) dut_if ();

    gray_sync_decoder #(
        .WIDTH       (4),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (dut_if.slave)
    );

    // Free-running destination clock, 10 ns period.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive the gray code for binary value b, queue its expected report, hold.
    task automatic applyStimulus(input logic [3:0] b, input int hold);
        exp_t e;
        e.bin   = b;
        e.delta = b - last_bin;
        exp_q.push_back(e);
        last_bin = b;
        dut_if.i_gray_async = gray_tab[b];
        repeat (hold) @(negedge i_clk);
    endtask

    // Monitor: every valid pulse must match the next queued expectation.
    always @(negedge i_clk) begin
        exp_t e;
        if (dut_if.o_err) err_pulses++;
        if (dut_if.o_bin_vld) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_vld: got pulse with o_bin=%0d, expected no pulse",
                         dut_if.o_bin);
            end else begin
                e = exp_q.pop_front();
                checkOutput("vld_bin", 32'(dut_if.o_bin), 32'(e.bin));
                checkOutput("vld_delta", 32'(dut_if.o_delta), 32'(e.delta));
                checkOutput("vld_err", 32'(dut_if.o_err), 32'd0);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        int p;
        i_rst = 1'b1;
        dut_if.i_gray_async = 4'b0110;
        last_bin = 4'd4;
        repeat (3) @(negedge i_clk);

        // Reset state.
        checkOutput("rst_bin", 32'(dut_if.o_bin), 32'd0);
        checkOutput("rst_vld", 32'(dut_if.o_bin_vld), 32'd0);
        checkOutput("rst_delta", 32'(dut_if.o_delta), 32'd0);
        checkOutput("rst_err", 32'(dut_if.o_err), 32'd0);
        checkOutput("rst_sticky", 32'(dut_if.o_err_sticky), 32'd0);

        // Held value through reset release loads after 3 edges, silently.
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        checkOutput("init_bin_early", 32'(dut_if.o_bin), 32'd0);
        @(negedge i_clk);
        checkOutput("init_bin_loaded", 32'(dut_if.o_bin), 32'd4);
        checkOutput("init_no_vld", 32'(dut_if.o_bin_vld), 32'd0);

        // Count up to 15, then a full lap 0..15 (includes the 15 -> 0 wrap).
        for (int b = 5; b < 16; b++) applyStimulus(4'(b), 3);
        for (int b = 0; b < 16; b++) applyStimulus(4'(b), 3);
        checkOutput("count_final_bin", 32'(dut_if.o_bin), 32'd15);

        // Wrap to 0, then a one-cycle two-bit jump 0000 -> 0011 -> 0000.
        applyStimulus(4'd0, 3);
        dut_if.i_gray_async = 4'b0011;
`ifdef GRAY_CHECK_EN
        err_exp = 1;
`else
        begin
            exp_t e;
            e.bin = 4'd2; e.delta = 4'd2; exp_q.push_back(e);
            e.bin = 4'd0; e.delta = 4'd14; exp_q.push_back(e);
        end
`endif
        @(negedge i_clk);
        dut_if.i_gray_async = 4'b0000;
        repeat (5) @(negedge i_clk);
        checkOutput("jump_bin", 32'(dut_if.o_bin), 32'd0);
        checkOutput("jump_err_pulses", 32'(err_pulses), 32'(err_exp));
        checkOutput("jump_sticky", 32'(dut_if.o_err_sticky), 32'(err_exp));
        last_bin = 4'd0;

        // Count to 9, then a one-cycle reset while the source moves to 10.
        for (int b = 1; b < 10; b++) applyStimulus(4'(b), 3);
        checkOutput("pre_rst_bin", 32'(dut_if.o_bin), 32'd9);
        i_rst = 1'b1;
        dut_if.i_gray_async = gray_tab[10];
        @(negedge i_clk);
        checkOutput("midrst_bin", 32'(dut_if.o_bin), 32'd0);
        checkOutput("midrst_delta", 32'(dut_if.o_delta), 32'd0);
        checkOutput("midrst_vld", 32'(dut_if.o_bin_vld), 32'd0);
        checkOutput("midrst_sticky", 32'(dut_if.o_err_sticky), 32'd0);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        checkOutput("refill_bin_early", 32'(dut_if.o_bin), 32'd0);
        @(negedge i_clk);
        checkOutput("refill_bin", 32'(dut_if.o_bin), 32'd10);
        last_bin = 4'd10;

        // Jittered source, period 25..29 ns, 200 single steps.
        #3;
        for (int s = 0; s < 200; s++) begin
            exp_t e;
            e.bin   = last_bin + 4'd1;
            e.delta = 4'd1;
            exp_q.push_back(e);
            last_bin = e.bin;
            dut_if.i_gray_async = gray_tab[e.bin];
            p = int'($urandom_range(25, 29));
            #(p);
        end
        repeat (10) @(negedge i_clk);
        checkOutput("jitter_final_bin", 32'(dut_if.o_bin), 32'(last_bin));
        checkOutput("jitter_sticky", 32'(dut_if.o_err_sticky), 32'd0);
        checkOutput("total_err_pulses", 32'(err_pulses), 32'(err_exp));
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
